// File: rtl/mips_cpu_alu_registers.sv
// MIPS datapath core: 32x32 register file (async clear, $zero hardwired) and a
// purely combinational ALU with a result-is-zero flag.
module mips_cpu_alu_registers (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEnable,
  input  logic [31:0] dataIn,
  input  logic [4:0]  writeAddress,
  input  logic [4:0]  readAddressA,
  output logic [31:0] readDataA,
  input  logic [4:0]  readAddressB,
  output logic [31:0] readDataB,
  output logic [31:0] register_v0,
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  output logic [31:0] r,
  output logic        zero
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_XOR  = 4'b0010, OP_NOR  = 4'b0011,
    OP_ADD  = 4'b0100, OP_SUB  = 4'b0101, OP_SLT  = 4'b0110, OP_SLTU = 4'b0111,
    OP_SLL  = 4'b1000, OP_SRL  = 4'b1001, OP_SRA  = 4'b1010, OP_SLLV = 4'b1011,
    OP_SRLV = 4'b1100, OP_SRAV = 4'b1101, OP_LUI  = 4'b1110, OP_NONE = 4'b1111
  } alu_op_e;

  // Entry 0 is cleared by reset and never written, so it always reads 0.
  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (writeEnable && (writeAddress != 5'd0)) begin
      regs_q[writeAddress] <= dataIn;
    end
  end

  // No write bypass: reads see the value held before the edge.
  assign readDataA   = regs_q[readAddressA];
  assign readDataB   = regs_q[readAddressB];
  assign register_v0 = regs_q[2];

  logic [4:0]  shamt;
  logic [31:0] r_d;

  always_comb begin
    shamt = control inside {OP_SLLV, OP_SRLV, OP_SRAV} ? a[4:0] : sa;
    r_d   = '0;
    unique case (alu_op_e'(control))
      OP_AND:  r_d = a & b;
      OP_OR:   r_d = a | b;
      OP_XOR:  r_d = a ^ b;
      OP_NOR:  r_d = ~(a | b);
      OP_ADD:  r_d = a + b;
      OP_SUB:  r_d = a - b;
      OP_SLT:  r_d = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r_d = {31'd0, a < b};
      OP_SLL, OP_SLLV: r_d = b << shamt;
      OP_SRL, OP_SRLV: r_d = b >> shamt;
      OP_SRA, OP_SRAV: r_d = $unsigned($signed(b) >>> shamt);
      OP_LUI:  r_d = {b[15:0], 16'h0000};
      OP_NONE: r_d = '0;
    endcase
  end

  assign r    = r_d;
  assign zero = (r_d == 32'h0);

endmodule

// File: tb/tb_mips_cpu_alu_registers.sv
// Directed bench for mips_cpu_alu_registers: an array/arithmetic reference model
// checked every negedge, plus hand-computed literal vectors.
module tb_mips_cpu_alu_registers;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        writeEnable = 1'b0;
  logic [31:0] dataIn = '0;
  logic [4:0]  writeAddress = '0, readAddressA = '0, readAddressB = '0;
  logic [31:0] readDataA, readDataB, register_v0;
  logic [3:0]  control = 4'hF;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  sa = '0;
  logic [31:0] r;
  logic        zero;

  int checks = 0;
  int errors = 0;

  mips_cpu_alu_registers dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .dataIn(dataIn),
    .writeAddress(writeAddress), .readAddressA(readAddressA), .readDataA(readDataA),
    .readAddressB(readAddressB), .readDataB(readDataB), .register_v0(register_v0),
    .control(control), .a(a), .b(b), .sa(sa), .r(r), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference register file
  logic [31:0] mregs [32];
  initial for (int i = 0; i < 32; i++) mregs[i] = '0;
  always @(negedge reset) for (int i = 0; i < 32; i++) mregs[i] = '0;
  always @(posedge clk)
    if (reset && writeEnable && writeAddress != 0) mregs[writeAddress] = dataIn;

  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] x,
                                            input logic [31:0] y, input logic [4:0] s);
    int unsigned amt;
    logic [31:0] fill;
    amt = (c >= 4'd11 && c <= 4'd13) ? int'(x % 32) : int'(s);
    fill = (amt == 0) ? 32'h0 : ~(32'hFFFF_FFFF >> amt);
    case (c)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x ^ y;
      4'd3:  return ~(x | y);
      4'd4:  return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
      4'd5:  return 32'((64'h1_0000_0000 + 64'(x) - 64'(y)) % 64'h1_0000_0000);
      4'd6:  return (longint'(int'(x)) < longint'(int'(y))) ? 32'd1 : 32'd0;
      4'd7:  return (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
      4'd8, 4'd11:  return 32'(64'(y) * (64'd1 << amt));
      4'd9, 4'd12:  return y / (32'd1 << amt);
      4'd10, 4'd13: return (y / (32'd1 << amt)) | (y[31] ? fill : 32'h0);
      4'd14: return y * 32'h1_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Continuous compare against the model
  always @(negedge clk) begin
    logic [31:0] er;
    er = model_alu(control, a, b, sa);
    check("cmp_readDataA", readDataA, mregs[readAddressA]);
    check("cmp_readDataB", readDataB, mregs[readAddressB]);
    check("cmp_v0", register_v0, mregs[2]);
    check("cmp_r", r, er);
    check("cmp_zero", {31'd0, zero}, {31'd0, er == 0});
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [4:0] ad, input logic [31:0] d);
    step();
    writeEnable = 1'b1; writeAddress = ad; dataIn = d;
    step();
    writeEnable = 1'b0;
  endtask

  typedef struct { logic [3:0] c; logic [31:0] x, y; logic [4:0] s; logic [31:0] e; } vec_t;
  vec_t vecs[$];

  initial begin
    #3;
    check("reset_v0", register_v0, 32'h0);
    check("reset_rdA", readDataA, 32'h0);
    #20 reset = 1'b1;

    // $v0 write and $zero write-ignore
    wr(5'd2, 32'hDEADBEEF);
    wr(5'd0, 32'h12345678);
    readAddressA = 5'd0; readAddressB = 5'd2; #1;
    check("v0_deadbeef", register_v0, 32'hDEADBEEF);
    check("r0_reads_zero", readDataA, 32'h0);

    // Same-cycle read/write, no bypass
    wr(5'd5, 32'h55);
    step();
    writeEnable = 1'b1; writeAddress = 5'd5; dataIn = 32'd7; readAddressA = 5'd5; #1;
    check("rw_before_edge", readDataA, 32'h55);
    @(posedge clk); #1;
    check("rw_after_edge", readDataA, 32'd7);
    writeEnable = 1'b0;

    // A few more writes, sampled by the compare process
    for (int i = 1; i < 32; i += 3) begin
      wr(5'(i), 32'hA000_0000 + i);
      readAddressA = 5'(i); readAddressB = 5'(i - 1);
    end

    // Mid-cycle reset pulse, no clock edge
    step();
    readAddressA = 5'd5; readAddressB = 5'd2;
    reset = 1'b0; #1;
    check("async_rst_v0", register_v0, 32'h0);
    check("async_rst_rdA", readDataA, 32'h0);
    check("async_rst_rdB", readDataB, 32'h0);
    #1 reset = 1'b1;

    // Writes suppressed while reset held across an edge
    wr(5'd2, 32'h1111_2222);
    step();
    reset = 1'b0; writeEnable = 1'b1; writeAddress = 5'd3; dataIn = 32'hBAD0_BAD0;
    step();
    readAddressA = 5'd3; #1;
    check("wr_in_reset", readDataA, 32'h0);
    check("v0_cleared", register_v0, 32'h0);
    reset = 1'b1; #1;
    check("post_rel_no_edge", readDataA, 32'h0);
    @(posedge clk); #1;
    check("first_wr_after_rel", readDataA, 32'hBAD0_BAD0);
    writeEnable = 1'b0;

    // ALU literal vectors
    vecs.push_back('{4'd4,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0});
    vecs.push_back('{4'd5,  32'h0,        32'h1,        5'd0,  32'hFFFFFFFF});
    vecs.push_back('{4'd6,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1});
    vecs.push_back('{4'd7,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0});
    vecs.push_back('{4'd10, 32'h0,        32'h80000000, 5'd4,  32'hF8000000});
    vecs.push_back('{4'd13, 32'h24,       32'h80000000, 5'd0,  32'hF8000000});
    vecs.push_back('{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h0});
    vecs.push_back('{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000});
    vecs.push_back('{4'd1,  32'hF0F0F0F0, 32'h0F000F00, 5'd0,  32'hFFF0FFF0});
    vecs.push_back('{4'd2,  32'hFFFF0000, 32'hFF00FF00, 5'd0,  32'h00FFFF00});
    vecs.push_back('{4'd3,  32'h0,        32'h0,        5'd0,  32'hFFFFFFFF});
    vecs.push_back('{4'd8,  32'h0,        32'h1234,     5'd0,  32'h1234});
    vecs.push_back('{4'd10, 32'h0,        32'h80000000, 5'd31, 32'hFFFFFFFF});
    vecs.push_back('{4'd9,  32'h0,        32'h80000000, 5'd31, 32'h1});
    vecs.push_back('{4'd14, 32'h0,        32'hABCD1234, 5'd0,  32'h12340000});
    vecs.push_back('{4'd11, 32'hFFFFFFE1, 32'h1,        5'd9,  32'h2});
    vecs.push_back('{4'd12, 32'hFFFFFFE4, 32'hF0000000, 5'd0,  32'h0F000000});
    vecs.push_back('{4'd6,  32'h1,        32'hFFFFFFFF, 5'd0,  32'h0});
    vecs.push_back('{4'd7,  32'h1,        32'hFFFFFFFF, 5'd0,  32'h1});
    foreach (vecs[i]) begin
      step();
      control = vecs[i].c; a = vecs[i].x; b = vecs[i].y; sa = vecs[i].s; #1;
      check($sformatf("alu_r_%0d", i), r, vecs[i].e);
      check($sformatf("alu_zero_%0d", i), {31'd0, zero}, {31'd0, vecs[i].e == 0});
    end

    // Operand sweep over every opcode, checked by the compare process
    for (int i = 0; i < 64; i++) begin
      step();
      control = 4'(i); a = $urandom; b = $urandom; sa = 5'($urandom);
      if (i % 8 == 7) b = 32'h8000_0000 | b;
    end

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mips_cpu_alu_registers.md
MIPS_CPU_ALU_REGISTERS -- requirements
Module: mips_cpu_alu_registers

Interface
REQ-001 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-004 writeEnable  in  1  register-file write strobe.
REQ-005 dataIn  in  32  register-file write data.
REQ-006 writeAddress  in  5  register-file write index.
REQ-007 readAddressA  in  5  read port A index.
REQ-008 readDataA  out  32  read port A data.
REQ-009 readAddressB  in  5  read port B index.
REQ-010 readDataB  out  32  read port B data.
REQ-011 register_v0  out  32  live contents of register 2 ($v0).
REQ-012 control  in  4  ALU operation select.
REQ-013 a  in  32  ALU operand A (rs value).
REQ-014 b  in  32  ALU operand B (rt value or extended immediate).
REQ-015 sa  in  5  ALU shift amount for fixed shifts.
REQ-016 r  out  32  ALU result.
REQ-017 zero  out  1  high when r == 0.

Function -- register file
REQ-018 SHALL hold 32 registers of 32 bits.
REQ-019 SHALL write dataIn into register[writeAddress] on rising clk when writeEnable=1 and reset=1.
REQ-020 Register 0 SHALL always read 0; writes to index 0 SHALL be ignored.
REQ-021 Read ports A and B SHALL be combinational (same-cycle) from the current register contents.
REQ-022 Same-cycle read/write of one index SHALL return the old value until the edge, the new value after it (no bypass).
REQ-023 register_v0 SHALL combinationally equal register 2.

Function -- ALU (purely combinational; no latency)
REQ-024 control 0000 AND: r = a & b.
REQ-025 0001 OR: r = a | b.
REQ-026 0010 XOR: r = a ^ b.
REQ-027 0011 NOR: r = ~(a | b).
REQ-028 0100 ADD: r = a + b mod 2^32; no overflow trap or flag (ADDU/ADDIU/address calc).
REQ-029 0101 SUB: r = a - b mod 2^32; no trap.
REQ-030 0110 SLT: r = 1 if signed a < signed b, else 0.
REQ-031 0111 SLTU: r = 1 if unsigned a < unsigned b, else 0.
REQ-032 1000 SLL: r = b << sa; 1001 SRL: r = b >> sa (logical); 1010 SRA: r = b >>> sa (sign-filling).
REQ-033 1011 SLLV / 1100 SRLV / 1101 SRAV: as 1000/1001/1010 using a[4:0] as the amount; a[31:5] ignored.
REQ-034 1110 LUI: r = {b[15:0], 16'h0000}.
REQ-035 1111 NONE (ALU unused): r = 0.
REQ-036 zero SHALL be 1 exactly when r == 32'h00000000, for every control value including 1111.
REQ-037 Shift by 0 SHALL return b unchanged; SRA of a negative b by 31 SHALL return 32'hFFFFFFFF.
REQ-038 ALU outputs SHALL depend only on control/a/b/sa; clk and reset SHALL NOT affect them.

Reset
REQ-039 While reset=0, all 32 registers SHALL clear to 0 immediately, without waiting for clk; register_v0, readDataA and readDataB SHALL read 0.
REQ-040 Writes SHALL be suppressed while reset=0, including when writeEnable=1 at a clk edge.
REQ-041 Reset asserted between write requests SHALL leave all registers 0; the first write after reset release SHALL take effect on the next rising edge with reset=1.

Verification
REQ-042 Pulse reset low mid-cycle with no clk edge -> register_v0 and all read ports = 0 immediately.
REQ-043 Write 32'hDEADBEEF to index 2, then 0x12345678 to index 0 -> register_v0 = DEADBEEF; readDataA at index 0 = 0.
REQ-044 Same cycle: writeAddress=5, readAddressA=5, dataIn=7 -> readDataA = old value before the edge, 7 after it.
REQ-045 control=0100, a=FFFFFFFF, b=1 -> r=0, zero=1; control=0101, a=0, b=1 -> r=FFFFFFFF, zero=0.
REQ-046 control=0110, a=FFFFFFFF, b=1 -> r=1; control=0111, same operands -> r=0.
REQ-047 control=1010, b=80000000, sa=4 -> r=F8000000; control=1101, a=0x24, b=80000000 -> r=F8000000; control=1111 -> r=0, zero=1.
